// File: rtl/mem_arbiter_pkg.sv
// Shared state and owner codes for the unified-memory arbiter.
package mem_arbiter_pkg;
   typedef enum logic [1:0] {
      ARB_IDLE  = 2'd0,
      ARB_ISSUE = 2'd1,
      ARB_WAIT  = 2'd2,
      ARB_DONE  = 2'd3
   } arb_state_t;

   localparam logic OWN_CPU = 1'b0;
   localparam logic OWN_DMA = 1'b1;

   // Wide enough for MEM_LAT up to 4.
   localparam int LAT_W = 3;
endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input grant: round-robin on ties (or CPU-first when FIXED_PRIO), with last-owner register.
module rr_arb2
   import mem_arbiter_pkg::*;
#(
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_req_cpu,
   input  logic i_req_dma,
   input  logic i_en,
   output logic o_gnt_valid,
   output logic o_gnt_dma,
   output logic o_last_dma
);
   logic r_last;
   logic w_gnt;
   logic w_valid;

   always_comb begin
      w_valid = i_en & (i_req_cpu | i_req_dma);
      if (i_req_cpu & i_req_dma)
         w_gnt = FIXED_PRIO ? OWN_CPU : ~r_last;
      else
         w_gnt = i_req_dma;
   end

   // Reset to DMA so the CPU wins the first tie.
   always_ff @(posedge clk) begin
      if (rst)
         r_last <= OWN_DMA;
      else if (w_valid)
         r_last <= w_gnt;
   end

   assign o_gnt_valid = w_valid;
   assign o_gnt_dma   = w_gnt;
   assign o_last_dma  = r_last;
endmodule

// File: rtl/mem_arbiter.sv
// Shares the single memory port between CPU and DMA; one fixed-latency access at a time.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int AW         = 32,
   parameter int DW         = 32,
   parameter int MEM_LAT    = 1,
   parameter bit FIXED_PRIO = 1'b0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cpu_req,
   input  logic          cpu_we,
   input  logic [AW-1:0] cpu_addr,
   input  logic [DW-1:0] cpu_wdata,
   output logic [DW-1:0] cpu_rdata,
   output logic          cpu_ack,
   output logic          cpu_stall,
   input  logic          dma_req,
   input  logic          dma_we,
   input  logic [AW-1:0] dma_addr,
   input  logic [DW-1:0] dma_wdata,
   output logic [DW-1:0] dma_rdata,
   output logic          dma_ack,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          owner,
   output logic [1:0]    state
);
   arb_state_t       r_state;
   logic [LAT_W-1:0] r_cnt;
   logic             r_mem_en;
   logic             r_mem_we;
   logic [AW-1:0]    r_mem_addr;
   logic [DW-1:0]    r_mem_wdata;
   logic             r_cpu_ack;
   logic             r_dma_ack;
   logic [DW-1:0]    r_cpu_rdata;
   logic [DW-1:0]    r_dma_rdata;
   logic             w_gnt_valid;
   logic             w_gnt_dma;
   logic             w_owner;

   rr_arb2 #(.FIXED_PRIO(FIXED_PRIO)) u_arb (
      .clk         (clk),
      .rst         (rst),
      .i_req_cpu   (cpu_req),
      .i_req_dma   (dma_req),
      .i_en        (r_state == ARB_IDLE),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_dma   (w_gnt_dma),
      .o_last_dma  (w_owner)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= ARB_IDLE;
         r_cnt       <= '0;
         r_mem_en    <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_addr  <= '0;
         r_mem_wdata <= '0;
         r_cpu_ack   <= 1'b0;
         r_dma_ack   <= 1'b0;
         r_cpu_rdata <= '0;
         r_dma_rdata <= '0;
      end else begin
         r_mem_en  <= 1'b0;
         r_cpu_ack <= 1'b0;
         r_dma_ack <= 1'b0;
         case (r_state)
            ARB_IDLE: begin
               if (w_gnt_valid) begin
                  r_mem_we    <= w_gnt_dma ? dma_we    : cpu_we;
                  r_mem_addr  <= w_gnt_dma ? dma_addr  : cpu_addr;
                  r_mem_wdata <= w_gnt_dma ? dma_wdata : cpu_wdata;
                  r_mem_en    <= 1'b1;
                  r_state     <= ARB_ISSUE;
               end
            end
            ARB_ISSUE: begin
               r_cnt   <= LAT_W'(MEM_LAT);
               r_state <= ARB_WAIT;
            end
            ARB_WAIT: begin
               r_cnt <= r_cnt - LAT_W'(1);
               // Last WAIT cycle is exactly MEM_LAT cycles after mem_en: read data is valid now.
               if (r_cnt == LAT_W'(1)) begin
                  r_state <= ARB_DONE;
                  if (w_owner == OWN_DMA) begin
                     r_dma_rdata <= mem_rdata;
                     r_dma_ack   <= 1'b1;
                  end else begin
                     r_cpu_rdata <= mem_rdata;
                     r_cpu_ack   <= 1'b1;
                  end
               end
            end
            ARB_DONE: r_state <= ARB_IDLE;
            default:  r_state <= ARB_IDLE;
         endcase
      end
   end

   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_en & r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign cpu_ack   = r_cpu_ack;
   assign dma_ack   = r_dma_ack;
   assign cpu_rdata = r_cpu_rdata;
   assign dma_rdata = r_dma_rdata;
   assign cpu_stall = cpu_req & ~r_cpu_ack;
   assign owner     = w_owner;
   assign state     = r_state;
endmodule
